// File: rtl/adc_fifo_pkg.sv
// Shared definitions for the ADC sample FIFO path: controller state encodings,
// reader FSM states, FIFO geometry defaults and HPS buffer word layout.
package adc_fifo_pkg;

    typedef enum logic [2:0] {
        CTRL_START   = 3'd0,
        CTRL_CONVST  = 3'd1,
        CTRL_ACQUIRE = 3'd2,
        CTRL_SHIFT   = 3'd3,
        CTRL_STORE   = 3'd4,
        CTRL_READ    = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_GRANT   = 2'd1,
        RD_POP     = 2'd2,
        RD_RELEASE = 2'd3
    } rd_state_t;

    localparam int unsigned ADC_FIFO_WORDS    = 256;
    localparam int unsigned ADC_FIFO_EXPONENT = 8;

    // Buffer word: {1'b0, ch[2:0], sample[11:0]}
    localparam int unsigned BUF_SAMPLE_LSB = 0;
    localparam int unsigned BUF_SAMPLE_W   = 12;
    localparam int unsigned BUF_CH_LSB     = 12;
    localparam int unsigned BUF_CH_W       = 3;

    function automatic logic [15:0] tag_sample(input logic [2:0] ch, input logic [11:0] sample);
        logic [15:0] w;
        w = '0;
        w[BUF_CH_LSB +: BUF_CH_W]         = ch;
        w[BUF_SAMPLE_LSB +: BUF_SAMPLE_W] = sample;
        return w;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Single-cycle pulse on a 0->1 transition of a synchronous level input.
module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_prev <= 1'b0;
        end else begin
            d_prev <= d;
        end
    end

    assign pulse = d & ~d_prev;

endmodule

// File: rtl/hps_fifo_reader.sv
// Drains one full frame from the ADC sample FIFO into the HPS-visible buffer
// once the channel controller grants the read, tagging each word with its channel.
module hps_fifo_reader
    import adc_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WORDS      = ADC_FIFO_WORDS,
    parameter int unsigned EXPONENT        = ADC_FIFO_EXPONENT,
    parameter logic [2:0]  CTRL_READ_STATE = CTRL_READ,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                adc_clk,
    input  logic                adc_reset,
    input  logic                hps_start,
    input  logic                hps_abort,
    input  logic [2:0]          adc_ctrl_state,
    input  logic [11:0]         fifo_q,
    input  logic                fifo_rdempty,
    input  logic [EXPONENT-1:0] fifo_usedw,
    output logic                hps_rdrq,
    output logic                fifo_rdreq,
    output logic                buf_we,
    output logic [EXPONENT-1:0] buf_addr,
    output logic [15:0]         buf_data,
    output logic                frame_done,
    output logic                frame_err,
    output logic                busy
);

    localparam logic [EXPONENT:0] TERM     = (EXPONENT+1)'(FIFO_WORDS);
    localparam logic [EXPONENT:0] TERM_M1  = (EXPONENT+1)'(FIFO_WORDS - 1);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    rd_state_t         state, state_nxt;
    logic [15:0]       tmo_cnt;
    logic [EXPONENT:0] issued, written;
    logic              rd_valid;
    logic              start_pulse;
    logic              granted;
    logic              clr_cnt, set_err, clr_err, done_nxt;
    logic              usedw_unused;

    assign usedw_unused = ^fifo_usedw;
    assign granted      = (adc_ctrl_state == CTRL_READ_STATE);

    rise_edge_det u_start_edge (
        .clk   (adc_clk),
        .reset (adc_reset),
        .d     (hps_start),
        .pulse (start_pulse)
    );

    always_comb begin
        state_nxt  = state;
        fifo_rdreq = 1'b0;
        clr_cnt    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start_pulse) begin
                    clr_cnt   = 1'b1;
                    clr_err   = 1'b1;
                    state_nxt = RD_GRANT;
                end
            end
            RD_GRANT: begin
                if (hps_abort) begin
                    set_err   = 1'b1;
                    state_nxt = RD_RELEASE;
                end else if (granted) begin
                    state_nxt = RD_POP;
                end else if (tmo_cnt == TMO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = RD_IDLE;
                end
            end
            RD_POP: begin
                // Losing the grant mid-frame is handled exactly like an abort.
                if (hps_abort || !granted) begin
                    set_err   = 1'b1;
                    state_nxt = RD_RELEASE;
                end else begin
                    fifo_rdreq = !fifo_rdempty && (issued < TERM);
                    if (rd_valid && (written == TERM_M1)) begin
                        state_nxt = RD_RELEASE;
                    end
                end
            end
            RD_RELEASE: begin
                if (!granted) begin
                    done_nxt  = !frame_err;
                    state_nxt = RD_IDLE;
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state      <= RD_IDLE;
            tmo_cnt    <= '0;
            issued     <= '0;
            written    <= '0;
            rd_valid   <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid   <= fifo_rdreq;
            frame_done <= done_nxt;
            if (clr_cnt) begin
                tmo_cnt <= '0;
                issued  <= '0;
                written <= '0;
            end else begin
                if (state == RD_GRANT) tmo_cnt <= tmo_cnt + 16'd1;
                if (fifo_rdreq)        issued  <= issued + (EXPONENT+1)'(1);
                if (rd_valid)          written <= written + (EXPONENT+1)'(1);
            end
            if (clr_err) begin
                frame_err <= 1'b0;
            end else if (set_err) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign hps_rdrq = (state == RD_GRANT) || (state == RD_POP);
    assign busy     = (state != RD_IDLE);
    assign buf_we   = rd_valid;
    assign buf_addr = written[EXPONENT-1:0];
    assign buf_data = rd_valid ? tag_sample(written[2:0], fifo_q) : '0;

endmodule

// File: tb/tb_hps_fifo_reader.sv
// Scoreboard bench for hps_fifo_reader with behavioural FIFO and controller models.
module tb_hps_fifo_reader;

    logic        clk = 1'b0;
    logic        adc_reset = 1'b1;
    logic        hps_start = 1'b0;
    logic        hps_abort = 1'b0;
    logic [2:0]  adc_ctrl_state;
    logic [11:0] fifo_q;
    logic        fifo_rdempty;
    logic [7:0]  fifo_usedw = 8'd0;
    logic        hps_rdrq, fifo_rdreq, buf_we, frame_done, frame_err, busy;
    logic [7:0]  buf_addr;
    logic [15:0] buf_data;

    always #5 clk = ~clk;

    hps_fifo_reader #(
        .FIFO_WORDS     (256),
        .EXPONENT       (8),
        .CTRL_READ_STATE(3'd5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .adc_clk       (clk),
        .adc_reset     (adc_reset),
        .hps_start     (hps_start),
        .hps_abort     (hps_abort),
        .adc_ctrl_state(adc_ctrl_state),
        .fifo_q        (fifo_q),
        .fifo_rdempty  (fifo_rdempty),
        .fifo_usedw    (fifo_usedw),
        .hps_rdrq      (hps_rdrq),
        .fifo_rdreq    (fifo_rdreq),
        .buf_we        (buf_we),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] fifo_mem[$];

    int n_checks = 0;
    int n_errors = 0;

    int we_total = 0, done_total = 0, rdrq_total = 0;
    int rdreq_total = 0, rdreq_empty_total = 0, pop_count = 0;
    int gap_at = -1, gap_done_at = -1, gap_left = 0;
    int grant_cnt = 0;
    int grant_delay = 10;
    logic grant_enable = 1'b1;
    logic rdreq_s = 1'b0, empty_s = 1'b1, rdrq_s = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor and scoreboard; also samples signals the models react to.
    initial forever begin
        @(negedge clk);
        rdreq_s = fifo_rdreq;
        empty_s = fifo_rdempty;
        rdrq_s  = hps_rdrq;
        if (hps_rdrq) rdrq_total++;
        if (buf_we) begin
            exp_t e;
            we_total++;
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("buf_addr", 32'(buf_addr), 32'(e.addr));
                check("buf_data", 32'(buf_data), 32'(e.data));
            end
        end
        if (frame_done) begin
            done_total++;
            check("done_after_ctrl_left", 32'(adc_ctrl_state == 3'd5), 32'd0);
        end
    end

    // FIFO model: normal-mode read, data one cycle after rdreq; optional empty gap.
    initial begin
        fifo_q       = '0;
        fifo_rdempty = 1'b1;
        forever begin
            @(posedge clk);
            if (rdreq_s) begin
                rdreq_total++;
                if (empty_s || fifo_mem.size() == 0) begin
                    rdreq_empty_total++;
                end else begin
                    fifo_q <= fifo_mem.pop_front();
                    pop_count++;
                end
            end
            if (gap_left > 0) gap_left--;
            if (pop_count == gap_at && gap_done_at != gap_at) begin
                gap_left    = 5;
                gap_done_at = gap_at;
            end
            fifo_rdempty <= (gap_left > 0) || (fifo_mem.size() == 0);
        end
    end

    // Controller model: grants after grant_delay cycles of request, leaves READ when released.
    initial begin
        adc_ctrl_state = 3'd0;
        forever begin
            @(posedge clk);
            if (adc_reset) begin
                adc_ctrl_state <= 3'd0;
                grant_cnt = 0;
            end else if (adc_ctrl_state == 3'd5) begin
                if (!rdrq_s) adc_ctrl_state <= 3'd0;
            end else if (rdrq_s && grant_enable) begin
                grant_cnt++;
                if (grant_cnt >= grant_delay) begin
                    adc_ctrl_state <= 3'd5;
                    grant_cnt = 0;
                end
            end else begin
                grant_cnt = 0;
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_frame(input bit ramp);
        for (int i = 0; i < 256; i++) begin
            logic [11:0] w;
            logic [7:0]  a;
            w = ramp ? 12'(i) : 12'($urandom_range(0, 4095));
            a = 8'(i);
            fifo_mem.push_back(w);
            exp_q.push_back('{addr: a, data: {1'b0, a[2:0], w}});
        end
    endtask

    task automatic flush_models();
        fifo_mem.delete();
        exp_q.delete();
    endtask

    task automatic start_frame(input string tag);
        hps_start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rdrq_1cyc"}, 32'(hps_rdrq), 32'd1);
        check({tag, "_err_clear"}, 32'(frame_err), 32'd0);
        hps_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (we_total < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reached"}, 32'(we_total >= target), 32'd1);
    endtask

    task automatic check_full_frame(input string tag, input int we0, input int done0, input int rdreq0);
        check({tag, "_we_count"}, 32'(we_total - we0), 32'd256);
        check({tag, "_rdreq_count"}, 32'(rdreq_total - rdreq0), 32'd256);
        check({tag, "_done_count"}, 32'(done_total - done0), 32'd1);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rdrq_low"}, 32'(hps_rdrq), 32'd0);
        check({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int we0, done0, rdreq0, rdrq0;

        cycles(3);
        check("reset_outputs",
              32'({hps_rdrq, fifo_rdreq, buf_we, buf_addr, buf_data, frame_done, frame_err, busy}),
              32'd0);
        adc_reset = 1'b0;
        cycles(3);

        // Full ramp frame, grant after 10 cycles
        load_frame(1'b1);
        cycles(2);
        we0 = we_total; done0 = done_total; rdreq0 = rdreq_total;
        check("pre_start_rdrq", 32'(hps_rdrq), 32'd0);
        start_frame("ramp");
        wait_idle("ramp", 700);
        cycles(3);
        check_full_frame("ramp", we0, done0, rdreq0);

        // Grant never arrives
        grant_enable = 1'b0;
        we0 = we_total; done0 = done_total; rdreq0 = rdreq_total; rdrq0 = rdrq_total;
        start_frame("tmo");
        wait_idle("tmo", 300);
        cycles(3);
        check("tmo_rdrq_cycles", 32'(rdrq_total - rdrq0), 32'd100);
        check("tmo_err", 32'(frame_err), 32'd1);
        check("tmo_no_rdreq", 32'(rdreq_total - rdreq0), 32'd0);
        check("tmo_no_done", 32'(done_total - done0), 32'd0);
        grant_enable = 1'b1;

        // Empty gap after word 40
        load_frame(1'b0);
        cycles(2);
        gap_at = pop_count + 40;
        we0 = we_total; done0 = done_total; rdreq0 = rdreq_total;
        start_frame("gap");
        wait_idle("gap", 700);
        cycles(3);
        check_full_frame("gap", we0, done0, rdreq0);
        check("gap_no_rdreq_empty", 32'(rdreq_empty_total), 32'd0);
        check("gap_happened", 32'(gap_done_at == gap_at), 32'd1);

        // Abort at word 100
        load_frame(1'b0);
        cycles(2);
        we0 = we_total; done0 = done_total;
        start_frame("abort");
        wait_writes("abort", we0 + 100, 400);
        hps_abort = 1'b1;
        cycles(2);
        hps_abort = 1'b0;
        wait_idle("abort", 50);
        cycles(3);
        check("abort_we_max", 32'(we_total - we0 <= 101), 32'd1);
        check("abort_we_min", 32'(we_total - we0 >= 100), 32'd1);
        check("abort_err", 32'(frame_err), 32'd1);
        check("abort_no_done", 32'(done_total - done0), 32'd0);
        check("abort_rdrq_low", 32'(hps_rdrq), 32'd0);
        check("abort_rdreq_low", 32'(fifo_rdreq), 32'd0);
        flush_models();
        cycles(3);

        // Reset at word 50, then a clean frame from addr 0
        load_frame(1'b0);
        cycles(2);
        we0 = we_total;
        start_frame("rst");
        wait_writes("rst", we0 + 50, 400);
        adc_reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_outputs_zero",
              32'({hps_rdrq, fifo_rdreq, buf_we, buf_addr, buf_data, frame_done, frame_err, busy}),
              32'd0);
        adc_reset = 1'b0;
        flush_models();
        cycles(4);
        load_frame(1'b0);
        cycles(2);
        we0 = we_total; done0 = done_total; rdreq0 = rdreq_total;
        start_frame("rst2");
        wait_idle("rst2", 700);
        cycles(3);
        check_full_frame("rst2", we0, done0, rdreq0);

        // Second start while busy is ignored
        load_frame(1'b0);
        cycles(2);
        we0 = we_total; done0 = done_total; rdreq0 = rdreq_total;
        start_frame("busy");
        cycles(20);
        hps_start = 1'b1;
        cycles(1);
        hps_start = 1'b0;
        wait_idle("busy", 700);
        cycles(6);
        check_full_frame("busy", we0, done0, rdreq0);
        check("busy_no_restart", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
